// File: rtl/usr_cmd_sequencer.sv
// Command sequencer for a universal shift register: queues (op, count, data)
// commands, drives the mode select / parallel input, and reports the result.
module usr_cmd_sequencer #(
  parameter int WIDTH = 4,
  parameter int CNT_W = 4,
  parameter int DEPTH = 2
) (
  input  logic             clk,
  input  logic             clear,
  input  logic             cmd_valid,
  output logic             cmd_ready,
  input  logic [2:0]       cmd_op,
  input  logic [CNT_W-1:0] cmd_count,
  input  logic [WIDTH-1:0] cmd_data,
  input  logic             abort,
  output logic [2:0]       usr_s,
  output logic [WIDTH-1:0] usr_i,
  input  logic [WIDTH-1:0] usr_q,
  output logic             busy,
  output logic             done,
  output logic             aborted,
  output logic [WIDTH-1:0] result
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [2:0] OP_LOAD = 3'd3;

  typedef enum logic [1:0] {
    S_IDLE,
    S_EXEC,
    S_DONE
  } state_e;

  state_e           state_q, state_d;
  logic [2:0]       op_q, op_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [WIDTH-1:0] data_q, data_d;
  logic             aborted_q, aborted_d;
  logic [WIDTH-1:0] result_q, result_d;
  logic [AW:0]      wr_ptr_q, wr_ptr_d;
  logic [AW:0]      rd_ptr_q, rd_ptr_d;

  logic [2:0]       op_mem_q   [DEPTH];
  logic [CNT_W-1:0] cnt_mem_q  [DEPTH];
  logic [WIDTH-1:0] data_mem_q [DEPTH];

  logic             fifo_empty;
  logic             fifo_full;
  logic             push;
  logic             pop;
  logic [2:0]       head_op;
  logic [CNT_W-1:0] head_cnt;
  logic [WIDTH-1:0] head_data;
  logic [CNT_W-1:0] head_n;

  // Extra pointer bit distinguishes full from empty when the indices match.
  assign fifo_empty = (wr_ptr_q == rd_ptr_q);
  assign fifo_full  = (wr_ptr_q[AW] != rd_ptr_q[AW]) &&
                      (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);

  assign cmd_ready = !fifo_full && !abort;
  assign push      = cmd_valid && cmd_ready;

  assign head_op   = op_mem_q[rd_ptr_q[AW-1:0]];
  assign head_cnt  = cnt_mem_q[rd_ptr_q[AW-1:0]];
  assign head_data = data_mem_q[rd_ptr_q[AW-1:0]];
  assign head_n    = (head_op == OP_LOAD) ? CNT_W'(1) : head_cnt;

  assign wr_ptr_d = wr_ptr_q + (AW+1)'(push);
  assign rd_ptr_d = abort ? wr_ptr_q : (rd_ptr_q + (AW+1)'(pop));

  always_ff @(posedge clk) begin
    if (push) begin
      op_mem_q[wr_ptr_q[AW-1:0]]   <= cmd_op;
      cnt_mem_q[wr_ptr_q[AW-1:0]]  <= cmd_count;
      data_mem_q[wr_ptr_q[AW-1:0]] <= cmd_data;
    end
  end

  always_ff @(posedge clk or negedge clear) begin
    if (!clear) begin
      state_q   <= S_IDLE;
      op_q      <= '0;
      cnt_q     <= '0;
      data_q    <= '0;
      aborted_q <= 1'b0;
      result_q  <= '0;
      wr_ptr_q  <= '0;
      rd_ptr_q  <= '0;
    end else begin
      state_q   <= state_d;
      op_q      <= op_d;
      cnt_q     <= cnt_d;
      data_q    <= data_d;
      aborted_q <= aborted_d;
      result_q  <= result_d;
      wr_ptr_q  <= wr_ptr_d;
      rd_ptr_q  <= rd_ptr_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    op_d      = op_q;
    cnt_d     = cnt_q;
    data_d    = data_q;
    aborted_d = aborted_q;
    result_d  = result_q;
    pop       = 1'b0;
    usr_s     = 3'd0;
    usr_i     = '0;
    done      = 1'b0;

    unique case (state_q)
      S_IDLE: begin
        if (abort) begin
          if (!fifo_empty) begin
            state_d   = S_DONE;
            aborted_d = 1'b1;
          end
        end else if (!fifo_empty) begin
          pop       = 1'b1;
          op_d      = head_op;
          cnt_d     = head_n;
          data_d    = head_data;
          aborted_d = 1'b0;
          state_d   = (head_n == '0) ? S_DONE : S_EXEC;
        end
      end

      S_EXEC: begin
        // An aborted cycle drives hold so its edge leaves the register untouched.
        if (abort) begin
          state_d   = S_DONE;
          aborted_d = 1'b1;
        end else begin
          usr_s = op_q;
          usr_i = (op_q == OP_LOAD) ? data_q : '0;
          if (cnt_q <= CNT_W'(1)) begin
            state_d   = S_DONE;
            aborted_d = 1'b0;
          end else begin
            cnt_d = cnt_q - CNT_W'(1);
          end
        end
      end

      S_DONE: begin
        done     = 1'b1;
        result_d = usr_q;
        if (!abort && !fifo_empty) begin
          pop       = 1'b1;
          op_d      = head_op;
          cnt_d     = head_n;
          data_d    = head_data;
          aborted_d = 1'b0;
          state_d   = (head_n == '0) ? S_DONE : S_EXEC;
        end else begin
          state_d = S_IDLE;
        end
      end

      default: state_d = S_IDLE;
    endcase
  end

  assign busy    = (state_q != S_IDLE) || !fifo_empty;
  assign aborted = (state_q == S_DONE) && aborted_q;
  assign result  = (state_q == S_DONE) ? usr_q : result_q;

endmodule

// File: tb/tb_usr_cmd_sequencer.sv
// Bench for usr_cmd_sequencer: a behavioural shift register closes the loop,
// and a queue of expected {aborted, result} pairs is checked on every done.
module tb_usr_cmd_sequencer;

  logic       clk = 1'b0;
  logic       clear = 1'b0;
  logic       cmd_valid = 1'b0;
  logic       cmd_ready;
  logic [2:0] cmd_op = '0;
  logic [3:0] cmd_count = '0;
  logic [3:0] cmd_data = '0;
  logic       abort = 1'b0;
  logic [2:0] usr_s;
  logic [3:0] usr_i;
  logic [3:0] usr_q;
  logic       busy, done, aborted;
  logic [3:0] result;

  int checks = 0;
  int failures = 0;
  int done_cnt = 0;
  int s_nz = 0, s5 = 0, s6 = 0;
  logic [4:0] exp_q[$];
  logic [3:0] model_reg = '0;

  usr_cmd_sequencer #(.WIDTH(4), .CNT_W(4), .DEPTH(2)) dut (
    .clk(clk), .clear(clear), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
    .cmd_op(cmd_op), .cmd_count(cmd_count), .cmd_data(cmd_data), .abort(abort),
    .usr_s(usr_s), .usr_i(usr_i), .usr_q(usr_q), .busy(busy), .done(done),
    .aborted(aborted), .result(result)
  );

  always #5 clk = ~clk;

  function automatic logic [3:0] apply(input logic [2:0] op, input logic [3:0] v,
                                       input logic [3:0] d);
    case (op)
      3'd1: apply = {v[2:0], 1'b0};
      3'd2: apply = {1'b0, v[3:1]};
      3'd3: apply = d;
      3'd4: apply = ~v;
      3'd5: apply = {v[2:0], v[3]};
      3'd6: apply = {v[0], v[3:1]};
      3'd7: apply = {v[1:0], v[3:2]};
      default: apply = v;
    endcase
  endfunction

  // Universal shift register the sequencer controls.
  always @(posedge clk or negedge clear) begin
    if (!clear) usr_q <= '0;
    else        usr_q <= apply(usr_s, usr_q, usr_i);
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  always @(negedge clk) begin
    if (clear === 1'b1) begin
      if (usr_s != 3'd0) s_nz++;
      if (usr_s == 3'd5) s5++;
      if (usr_s == 3'd6) s6++;
      if (usr_s != 3'd3) check("usr_i_zero", usr_i, 0);
      if (done === 1'b1) begin
        done_cnt++;
        if (exp_q.size() == 0) begin
          check("done_pending", exp_q.size(), 1);
        end else begin
          logic [4:0] e;
          e = exp_q.pop_front();
          check("result", result, e[3:0]);
          check("aborted", aborted, e[4]);
        end
      end
    end
  end

  task automatic sync();
    @(posedge clk); #1;
  endtask

  // Call at posedge+1; returns at posedge+1 after the accepting edge.
  task automatic push(input logic [2:0] op, input logic [3:0] cnt,
                      input logic [3:0] data, input bit exp_it);
    bit ok = 1'b0;
    logic [3:0] v;
    cmd_valid = 1'b1; cmd_op = op; cmd_count = cnt; cmd_data = data;
    for (int k = 0; k < 64; k++) begin
      @(negedge clk);
      if (cmd_ready === 1'b1) begin ok = 1'b1; break; end
    end
    @(posedge clk); #1;
    cmd_valid = 1'b0;
    check("push_accept", ok, 1);
    if (exp_it && ok) begin
      v = model_reg;
      if (op == 3'd3) v = data;
      else for (int k = 0; k < cnt; k++) v = apply(op, v, 4'd0);
      model_reg = v;
      exp_q.push_back({1'b0, v});
    end
  endtask

  task automatic wait_done(input int target, input int budget);
    for (int k = 0; k < budget; k++) begin
      @(negedge clk); #1;
      if (done_cnt >= target) break;
    end
    check("done_wait", (done_cnt >= target), 1);
  endtask

  initial begin
    repeat (3) @(posedge clk);
    @(negedge clk); clear = 1'b1;
    sync();
    check("rst_usr_s", usr_s, 0);
    check("rst_usr_i", usr_i, 0);
    check("rst_done", done, 0);
    check("rst_aborted", aborted, 0);
    check("rst_result", result, 0);
    check("rst_busy", busy, 0);
    check("rst_ready", cmd_ready, 1);

    // Reset in the middle of a long rotate.
    push(3'd5, 4'd9, 4'd0, 1'b0);
    sync(); #3;
    check("mid_exec_s", usr_s, 5);
    clear = 1'b0; #1;
    check("clr_usr_s", usr_s, 0);
    check("clr_busy", busy, 0);
    check("clr_done", done, 0);
    model_reg = '0;
    @(negedge clk); clear = 1'b1;
    sync();
    check("clr_ready", cmd_ready, 1);

    // Load then rotate back to back.
    done_cnt = 0; s5 = 0;
    push(3'd3, 4'd0, 4'b1011, 1'b1);
    push(3'd5, 4'd2, 4'd0, 1'b1);
    wait_done(1, 20);
    @(negedge clk);
    check("no_idle_bubble", usr_s, 5);
    wait_done(2, 20);
    check("rotl_cycles", s5, 2);

    // Load, shift right three times, invert.
    sync();
    done_cnt = 0;
    push(3'd3, 4'd0, 4'b1000, 1'b1);
    push(3'd2, 4'd3, 4'd0, 1'b1);
    wait_done(2, 30);
    sync();
    push(3'd4, 4'd1, 4'd0, 1'b1);
    wait_done(3, 20);

    // Fill the FIFO behind a 15-cycle command.
    sync();
    done_cnt = 0;
    push(3'd5, 4'd15, 4'd0, 1'b1);
    push(3'd4, 4'd1, 4'd0, 1'b1);
    push(3'd7, 4'd3, 4'd0, 1'b1);
    @(negedge clk);
    check("full_ready", cmd_ready, 0);
    repeat (5) @(negedge clk);
    check("full_ready_held", cmd_ready, 0);
    check("full_busy", busy, 1);
    wait_done(3, 100);
    check("last_done_busy", busy, 1);
    @(negedge clk);
    check("busy_drop", busy, 0);

    // Abort in the second cycle of a rotate-right with one queued.
    sync();
    done_cnt = 0; s6 = 0;
    push(3'd6, 4'd8, 4'd0, 1'b0);
    model_reg = apply(3'd6, model_reg, 4'd0);
    exp_q.push_back({1'b1, model_reg});
    push(3'd1, 4'd1, 4'd0, 1'b0);
    sync();
    abort = 1'b1;
    @(negedge clk);
    check("abort_ready", cmd_ready, 0);
    check("abort_usr_s", usr_s, 0);
    sync();
    abort = 1'b0;
    wait_done(1, 10);
    @(negedge clk);
    check("abort_idle", busy, 0);
    check("abort_rotr_cycles", s6, 1);
    repeat (4) @(negedge clk);
    check("abort_single_done", done_cnt, 1);

    // Zero count: done with no active cycle.
    sync();
    s_nz = 0;
    push(3'd1, 4'd0, 4'd0, 1'b1);
    @(negedge clk);
    check("cnt0_done_early", done, 0);
    @(negedge clk);
    check("cnt0_done", done, 1);
    repeat (3) @(negedge clk);
    check("cnt0_no_active", s_nz, 0);

    check("queue_drained", exp_q.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

endmodule
